// File: rtl/pe_alu_sequencer_if.sv
// Host-side and ALU-side signal bundle of the PE issue/writeback sequencer.
// slave = sequencer view, master = host/ALU view.
interface pe_alu_sequencer_if #(
   parameter int DWIDTH = 32,
   parameter int RF_AW  = 5,
   parameter int IM_AW  = 8
);
   localparam int IW = 4*RF_AW + 5;

   logic              Start;
   logic              Busy;
   logic              Done;
   logic              Inst_We;
   logic [IM_AW-1:0]  Inst_Addr;
   logic [IW-1:0]     Inst_Wdata;
   logic              Rf_We;
   logic [RF_AW-1:0]  Rf_Addr;
   logic [DWIDTH-1:0] Rf_Wdata;
   logic [DWIDTH-1:0] Rf_Rdata;
   logic [3:0]        Alu_Op;
   logic [DWIDTH-1:0] Alu_In0;
   logic [DWIDTH-1:0] Alu_In1;
   logic [DWIDTH-1:0] Alu_In2;
   logic [DWIDTH-1:0] Alu_Out;

   modport slave (
      input  Start, Inst_We, Inst_Addr, Inst_Wdata, Rf_We, Rf_Addr, Rf_Wdata, Alu_Out,
      output Busy, Done, Rf_Rdata, Alu_Op, Alu_In0, Alu_In1, Alu_In2
   );

   modport master (
      output Start, Inst_We, Inst_Addr, Inst_Wdata, Rf_We, Rf_Addr, Rf_Wdata, Alu_Out,
      input  Busy, Done, Rf_Rdata, Alu_Op, Alu_In0, Alu_In1, Alu_In2
   );
endinterface

// File: rtl/pe_alu_sequencer.sv
// PE issue/writeback controller: up to one ALU op per cycle, writeback ALU_LAT edges after issue.
// Issue stalls on RAW hazards and on opcode change while ops are in flight; host access only while idle.
module pe_alu_sequencer #(
   parameter int DWIDTH  = 32,
   parameter int RF_AW   = 5,
   parameter int IM_AW   = 8,
   parameter int ALU_LAT = 6
) (
   input logic              Clk,
   input logic              Reset,
   pe_alu_sequencer_if.slave io
);
   localparam int RF_N = 2**RF_AW;
   localparam int IM_N = 2**IM_AW;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic             last;
      logic [3:0]       op;
      logic [RF_AW-1:0] dst;
      logic [RF_AW-1:0] src0;
      logic [RF_AW-1:0] src1;
      logic [RF_AW-1:0] src2;
   } inst_t;

   state_t             state_q, state_d;
   logic [IM_AW-1:0]   pc_q, pc_d;
   inst_t              im [IM_N];
   inst_t              inst_q;
   logic               im_vld_q;
   logic [DWIDTH-1:0]  rf [RF_N];
   logic [DWIDTH-1:0]  rf_rdata_q;
   logic [ALU_LAT-1:0] dl_vld_q;
   logic [RF_AW-1:0]   dl_dst_q [ALU_LAT];
   logic [3:0]         alu_op_q;
   logic [DWIDTH-1:0]  alu_in0_q, alu_in1_q, alu_in2_q;

   logic busy;
   logic raw_hit;
   logic in_flight;
   logic op_hit;
   logic issue;
   logic inst_last;
   logic wb_vld;

   assign busy      = (state_q != S_IDLE);
   assign in_flight = |dl_vld_q;
   assign op_hit    = in_flight && (inst_q.op != alu_op_q);
   assign issue     = (state_q == S_ISSUE) && !raw_hit && !op_hit;
   assign inst_last = inst_q.last || (pc_q == '1);
   assign wb_vld    = dl_vld_q[ALU_LAT-1];

   // The writeback stage counts as in flight, so a same-cycle RF write/read never overlaps.
   always_comb begin
      raw_hit = 1'b0;
      for (int i = 0; i < ALU_LAT; i++) begin
         if (dl_vld_q[i] && ((dl_dst_q[i] == inst_q.src0) ||
                             (dl_dst_q[i] == inst_q.src1) ||
                             (dl_dst_q[i] == inst_q.src2)))
            raw_hit = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         S_IDLE: begin
            if (io.Start) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end
         end
         S_FETCH: begin
            if (im_vld_q)
               state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (issue) begin
               if (inst_last)
                  state_d = S_DRAIN;
               else
                  pc_d = pc_q + IM_AW'(1);
            end
         end
         S_DRAIN: begin
            if (!in_flight)
               state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         im_vld_q   <= 1'b0;
         dl_vld_q   <= '0;
         alu_op_q   <= '0;
         alu_in0_q  <= '0;
         alu_in1_q  <= '0;
         alu_in2_q  <= '0;
         rf_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         im_vld_q   <= (state_q == S_FETCH);
         dl_vld_q   <= {dl_vld_q[ALU_LAT-2:0], issue};
         rf_rdata_q <= rf[io.Rf_Addr];
         if (issue) begin
            alu_op_q  <= inst_q.op;
            alu_in0_q <= rf[inst_q.src0];
            alu_in1_q <= rf[inst_q.src1];
            alu_in2_q <= rf[inst_q.src2];
         end
      end
   end

   // Read address is the next PC so a new instruction is ready every cycle.
   always_ff @(posedge Clk) begin
      if (io.Inst_We && !busy)
         im[io.Inst_Addr] <= inst_t'(io.Inst_Wdata);
      inst_q <= im[pc_d];
   end

   always_ff @(posedge Clk) begin
      dl_dst_q[0] <= inst_q.dst;
      for (int i = 1; i < ALU_LAT; i++)
         dl_dst_q[i] <= dl_dst_q[i-1];
   end

   // Writebacks only happen while busy and host writes only while idle.
   always_ff @(posedge Clk) begin
      if (wb_vld)
         rf[dl_dst_q[ALU_LAT-1]] <= io.Alu_Out;
      else if (io.Rf_We && !busy)
         rf[io.Rf_Addr] <= io.Rf_Wdata;
   end

   assign io.Busy     = busy;
   assign io.Done     = (state_q == S_DONE);
   assign io.Rf_Rdata = rf_rdata_q;
   assign io.Alu_Op   = alu_op_q;
   assign io.Alu_In0  = alu_in0_q;
   assign io.Alu_In1  = alu_in1_q;
   assign io.Alu_In2  = alu_in2_q;
endmodule
